// File: rtl/iter_shifter_pkg.sv
// Shared types for the iterative shifter: operation modes and control states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRA = 2'b01,
        ROR = 2'b10,
        SRL = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle of the iterative shifter; the unit is the slave.
interface iter_shifter_if #(
    parameter int WIDTH = 16
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/iter_shifter_stage.sv
// One binary stage of the shifter: moves the operand by DIST bits when enabled.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] in,
    input  shift_mode_t      mode,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] shifted;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        shifted = in;
        unique case (mode)
            SLL: shifted = in << DIST;
            SRL: shifted = in >> DIST;
            SRA: shifted = {{DIST{in[WIDTH-1]}}, in[WIDTH-1:DIST]};
            ROR: shifted = {in[DIST-1:0], in[WIDTH-1:DIST]};
            default: shifted = in;
        endcase
        out = en ? shifted : in;
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: one binary stage of the shift amount per clock,
// fixed latency of log2(WIDTH) cycles, valid/ready on both sides.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_shifter_if.slave bus
);

    localparam int              LOG2W  = $clog2(WIDTH);
    localparam int              KW     = (LOG2W > 1) ? $clog2(LOG2W) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(LOG2W - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic [LOG2W-1:0] amt_q;
    shift_mode_t      mode_q;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [WIDTH-1:0] stage_out [LOG2W];
    logic             accept;
    logic             last_stage;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_stage = (state == SHIFT) && (k == K_LAST);

    // Every stage sees the working register; k picks which one is committed this cycle.
    for (genvar g = 0; g < LOG2W; g++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << g)
        ) u_stage (
            .in   (work),
            .mode (mode_q),
            .en   (amt_q[g]),
            .out  (stage_out[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
            SHIFT:   if (k == K_LAST)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            amt_q    <= '0;
            mode_q   <= SLL;
            k        <= '0;
            res_data <= '0;
            res_zero <= 1'b0;
        end else if (accept) begin
            work   <= bus.in_data;
            amt_q  <= bus.in_amt;
            mode_q <= shift_mode_t'(bus.in_mode);
            k      <= '0;
        end else if (state == SHIFT) begin
            work <= stage_out[k];
            k    <= k + 1'b1;
            // Result and flag are captured together so they stay stable through DONE.
            if (last_stage) begin
                res_data <= stage_out[k];
                res_zero <= ~|stage_out[k];
            end
        end
    end

    assign bus.out_data = res_data;
    assign bus.out_zero = res_zero;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: hand-computed 16-bit vectors, back-pressure,
// mid-operation reset, random 16-bit and exhaustive 8-bit checks against a bit-serial model.
module tb_iter_shifter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    iter_shifter_if #(.WIDTH(16)) b16 ();
    iter_shifter_if #(.WIDTH(8))  b8 ();

    iter_shifter #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    iter_shifter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bit per step, so it shares no structure with the staged datapath.
    function automatic logic [15:0] model(input int w, input logic [1:0] mode,
                                          input logic [15:0] d, input int amt);
        logic [15:0] r;
        logic [15:0] mask;
        logic        b;
        r    = d;
        mask = 16'((32'd1 << w) - 1);
        for (int i = 0; i < amt; i++) begin
            case (mode)
                2'b00: r = (r << 1) & mask;
                2'b11: r = r >> 1;
                2'b01: begin b = r[w-1]; r = r >> 1; r[w-1] = b; end
                default: begin b = r[0]; r = r >> 1; r[w-1] = b; end
            endcase
        end
        return r;
    endfunction

    task automatic wait_valid16(output int lat);
        lat = 0;
        while (!b16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run16(input string tag, input logic [1:0] mode, input logic [15:0] d,
                         input logic [3:0] amt, input logic [15:0] exp, input logic early);
        int lat;
        @(negedge clk);
        b16.in_valid  = 1'b1;
        b16.in_data   = d;
        b16.in_amt    = amt;
        b16.in_mode   = mode;
        b16.out_ready = early;
        check({tag, " in_ready"}, 32'(b16.in_ready), 1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        wait_valid16(lat);
        check({tag, " latency"}, 32'(lat), 4);
        check({tag, " data"}, 32'(b16.out_data), 32'(exp));
        check({tag, " zero"}, 32'(b16.out_zero), 32'(exp == 16'h0));
        if (!early) begin
            @(negedge clk);
            b16.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        check({tag, " idle"}, 32'({b16.in_ready, b16.out_valid}), 'b10);
    endtask

    task automatic run8(input logic [1:0] mode, input logic [7:0] d, input logic [2:0] amt);
        logic [15:0] e;
        int          lat;
        e = model(8, mode, {8'h00, d}, int'(amt));
        @(negedge clk);
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        b8.in_amt   = amt;
        b8.in_mode  = mode;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("w8 m%0d d%02h a%0d lat", mode, d, amt), 32'(lat), 3);
        check($sformatf("w8 m%0d d%02h a%0d res", mode, d, amt),
              32'({b8.out_zero, b8.out_data}), 32'({e == 16'h0, e[7:0]}));
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [1:0]  m;
        logic [15:0] d;
        logic [3:0]  a;

        rst_n = 1'b0;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_amt = '0; b16.in_mode = '0; b16.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_amt  = '0; b8.in_mode  = '0; b8.out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(b16.in_ready), 1);
        check("reset out_valid", 32'(b16.out_valid), 0);
        check("reset out_data", 32'(b16.out_data), 0);
        check("reset out_zero", 32'(b16.out_zero), 0);
        rst_n = 1'b1;

        // Directed vectors: mode 00 SLL, 01 SRA, 10 ROR, 11 SRL.
        run16("sll 0001>>15", 2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0);
        run16("sra 8000 15",  2'b01, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        run16("srl 8000 15",  2'b11, 16'h8000, 4'd15, 16'h0001, 1'b0);
        run16("sra 7ff0 4",   2'b01, 16'h7FF0, 4'd4,  16'h07FF, 1'b0);
        run16("ror 1234 4",   2'b10, 16'h1234, 4'd4,  16'h4123, 1'b0);
        run16("ror 1234 0",   2'b10, 16'h1234, 4'd0,  16'h1234, 1'b0);
        run16("srl 00ff 8",   2'b11, 16'h00FF, 4'd8,  16'h0000, 1'b0);
        run16("sll 00ff 8",   2'b00, 16'h00FF, 4'd8,  16'hFF00, 1'b0);
        run16("sra 8001 1",   2'b01, 16'h8001, 4'd1,  16'hC000, 1'b0);
        run16("ror 0001 1",   2'b10, 16'h0001, 4'd1,  16'h8000, 1'b0);
        run16("srl ffff 3",   2'b11, 16'hFFFF, 4'd3,  16'h1FFF, 1'b0);
        run16("ror a5c3 11",  2'b10, 16'hA5C3, 4'd11, 16'hB874, 1'b1);

        // Back-pressure: a second request is held on the input the whole time.
        @(negedge clk);
        b16.in_valid = 1'b1; b16.in_data = 16'h00FF; b16.in_amt = 4'd4; b16.in_mode = 2'b00;
        @(posedge clk); #1;
        b16.in_data = 16'hF000; b16.in_amt = 4'd12; b16.in_mode = 2'b11;
        wait_valid16(lat);
        check("bp first latency", 32'(lat), 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold valid", 32'(b16.out_valid), 1);
            check("bp hold data", 32'({b16.out_zero, b16.out_data}), 'h0FF0);
            check("bp hold in_ready", 32'(b16.in_ready), 0);
        end
        @(negedge clk);
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        check("bp after handshake", 32'({b16.in_ready, b16.out_valid}), 'b10);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        check("bp second accepted", 32'(b16.in_ready), 0);
        wait_valid16(lat);
        check("bp second latency", 32'(lat), 4);
        check("bp second data", 32'(b16.out_data), 'h000F);
        @(negedge clk);
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;

        // Reset in the middle of SHIFT drops the operation.
        @(negedge clk);
        b16.in_valid = 1'b1; b16.in_data = 16'h0001; b16.in_amt = 4'd15; b16.in_mode = 2'b00;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid reset ready/valid", 32'({b16.in_ready, b16.out_valid}), 'b10);
        check("mid reset out_data", 32'(b16.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post reset no valid", 32'(b16.out_valid), 0);
        run16("post reset sra", 2'b01, 16'h8000, 4'd3, 16'hF000, 1'b0);

        for (int i = 0; i < 60; i++) begin
            m = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            a = 4'($urandom_range(0, 15));
            run16($sformatf("rnd m%0d d%04h a%0d", m, d, a), m, d, a, model(16, m, d, int'(a)), 1'b0);
        end

        for (int mi = 0; mi < 4; mi++)
            for (int ai = 0; ai < 8; ai++)
                for (int di = 0; di < 256; di++)
                    run8(2'(mi), 8'(di), 3'(ai));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised shift/rotate unit with valid/ready handshakes on both sides. It resolves one binary stage of the shift amount per clock, so a WIDTH-bit operation has a fixed latency of log2(WIDTH) cycles. It sits beside the ALU as the successor to the single-cycle 16-bit SLL/SRA shifter. It adds logical right shift, rotate right, generic width, a zero flag and output back-pressure.

## Interface
- WIDTH, 16, operand width; power of two, ≥ 4
- LOG2W, $clog2(WIDTH), localparam; shift-amount width and latency
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- in_data  input  WIDTH  operand
- in_amt  input  LOG2W  shift amount, 0..WIDTH-1
- in_mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 SRL
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0

## Operation
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture data, amt and mode into internal registers.
  - Clear stage counter k to 0, then go to SHIFT.
- SHIFT, one edge per stage:
  - If amt[k] = 1, shift the working register by 2^k in the captured mode; otherwise hold it.
  - Increment k.
  - After stage LOG2W-1, go to DONE.
- DONE:
  - out_valid = 1; out_data and out_zero are held stable.
  - On out_ready, go to IDLE.
- Mode semantics:
  - SLL fills with 0.
  - SRA fills with the captured sign bit (MSB).
  - SRL fills with 0.
  - ROR wraps LSBs into MSBs.
- in_amt = 0 still traverses all stages, so latency is fixed.
- out_zero is computed from the final working register and registered together with it.
- Inputs are ignored outside IDLE. in_data, in_amt and in_mode are don't-care when not accepted.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_zero 0, k 0.
- Reset asserted mid-operation aborts the operation. The result is discarded and no out_valid is produced.

## Timing
- Accept handshake at edge T: in_valid & in_ready.
- Stages are applied at edges T+1 … T+LOG2W.
- out_valid rises after edge T+LOG2W, i.e. 4 cycles after accept for WIDTH=16.
- Output handshake at edge U: out_valid & out_ready. IDLE and in_ready = 1 from the cycle after U.
- Throughput is one op per LOG2W+2 cycles with no stalls.
- out_ready held low: out_valid, out_data and out_zero stay constant indefinitely, and in_ready stays 0.
- out_ready may be high before out_valid; it has no effect until DONE.
- in_ready and out_valid are never both 1.

## Structure
- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_mode_t: SLL=2'b00, SRA=2'b01, ROR=2'b10, SRL=2'b11.
  - typedef enum state_t: IDLE, SHIFT, DONE.
- Sub-module shift_stage is combinational.
  - Parameters: WIDTH and DIST (a power of two).
  - Ports: in, mode, en, out.
  - It is instantiated LOG2W times in a generate loop; k selects the active stage output.
- The top module contains the FSM, the capture registers, the stage counter and the output registers.

## Test plan
- SLL 0x0001, amt 15, accept at edge T → out_valid after edge T+4; out_data 0x8000; out_zero 0.
- SRA 0x8000, amt 15 → 0xFFFF. SRL 0x8000, amt 15 → 0x0001. SRA 0x7FF0, amt 4 → 0x07FF.
- ROR 0x1234, amt 4 → 0x4123. ROR 0x1234, amt 0 → 0x1234, still with 4-cycle latency.
- Zero flag:
  - SRL 0x00FF, amt 8 → 0x0000, out_zero 1.
  - SLL 0x00FF, amt 8 → 0xFF00, out_zero 0.
- Back-pressure: out_ready low 10 cycles while in_valid is held high with a new request.
  - Result stays stable and in_ready stays 0.
  - The new request is accepted only in the cycle after the output handshake.
- Reset and exhaustive check:
  - rst_n pulsed low during SHIFT → out_valid 0 and in_ready 1 immediately.
  - The next operation completes correctly.
  - WIDTH=8: exhaustive data × amt × mode against a behavioural model.
  - WIDTH=16: random checking against the same model.
